// File: rtl/jk_register_bank_pkg.sv
// Shared definitions for the JK register bank: operating mode encodings.
package jk_register_bank_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_e;

endpackage

// File: rtl/jk_register_bank_jk_cell.sv
// Single-bit JK flip-flop with asynchronous active-low reset to a supplied value.
module jk_cell
  import jk_register_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= rst_val;
    end else if (en) begin
      unique case ({j, k})
        2'b00:   r_q <= r_q;
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        default: r_q <= ~r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK cells usable as a JK register, loadable register or
// up/down counter, with a terminal-count flag and a registered limit pulse.
module jk_register_bank
  import jk_register_bank_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               WRAP        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_tog_up;
  logic [WIDTH-1:0] w_tog_dn;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_limit;
  logic             w_sat;
  logic             r_ovf;

  // Ripple toggle conditions: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    w_tog_up    = '0;
    w_tog_dn    = '0;
    w_tog_up[0] = 1'b1;
    w_tog_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_tog_up[i] = w_tog_up[i-1] & w_q[i-1];
      w_tog_dn[i] = w_tog_dn[i-1] & ~w_q[i-1];
    end
  end

  always_comb begin
    w_limit = 1'b0;
    unique case (mode)
      MODE_UP:   w_limit = &w_q;
      MODE_DOWN: w_limit = ~|w_q;
      default:   w_limit = 1'b0;
    endcase
  end

  assign tc    = en & w_limit;
  assign w_sat = w_limit & ~WRAP;

  // Saturation is realised by steering every cell to hold (J=K=0).
  always_comb begin
    w_j = '0;
    w_k = '0;
    unique case (mode)
      MODE_JK: begin
        w_j = j;
        w_k = k;
      end
      MODE_LOAD: begin
        w_j = d;
        w_k = ~d;
      end
      MODE_UP: begin
        w_j = w_tog_up;
        w_k = w_tog_up;
      end
      default: begin
        w_j = w_tog_dn;
        w_k = w_tog_dn;
      end
    endcase
    if (w_sat) begin
      w_j = '0;
      w_k = '0;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VALUE[g]),
      .en      (en),
      .j       (w_j[g]),
      .k       (w_k[g]),
      .q       (w_q[g])
    );
  end

  // A limit event is exactly an enabled edge with tc high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= tc;
    end
  end

  assign q   = w_q;
  assign ovf = r_ovf;

endmodule
